rf_move_sequencer: RTL and testbench

- Command front-end for the register-file move engine.
- Accepts move commands (src, dst, length in lines) from the instruction decoder into a small FIFO.
- Splits commands longer than the engine's line-count field into legal chunks.
- Drives the move engine's start/address/line-count inputs one chunk at a time and tracks its done flag; sits directly upstream of the move engine.

---
 rtl/rf_move_pkg.sv | 24 ++
 rtl/rf_cmd_fifo.sv | 53 +++++
 rtl/rf_move_sequencer.sv | 131 +++++++++++++
 tb/tb_rf_move_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_move_pkg.sv
// Shared types and helpers for the register-file move sequencer and its command FIFO.
package rf_move_pkg;

  localparam int CMD_ADDR_W = 10;
  localparam int CMD_LEN_W  = 12;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } seq_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] src;
    logic [CMD_ADDR_W-1:0] dst;
    logic [CMD_LEN_W-1:0]  len;
  } move_cmd_t;

  function automatic int unsigned max_chunk(input int unsigned line_num_w);
    return (32'd1 << line_num_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rf_cmd_fifo.sv
// Synchronous FIFO of move commands; pushes while full and pops while empty are ignored.
module rf_cmd_fifo
  import rf_move_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  move_cmd_t wr_data,
  input  logic      pop,
  output move_cmd_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  move_cmd_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rf_move_sequencer.sv
// Queues move commands and feeds them to the move engine in chunks the engine's
// line-count field can express, one start pulse per chunk.
module rf_move_sequencer
  import rf_move_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int LINE_NUM_W = 8,
  parameter int LEN_W      = CMD_LEN_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_src_addr,
  input  logic [ADDR_W-1:0]     cmd_dst_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  mv_start,
  output logic [ADDR_W-1:0]     mv_src_addr,
  output logic [ADDR_W-1:0]     mv_dst_addr,
  output logic [LINE_NUM_W-1:0] mv_line_num,
  input  logic                  mv_done,
  output logic                  cmd_done,
  output logic                  busy,
  output logic                  err_zero_len,
  input  logic                  err_clr
);

  localparam logic [LINE_NUM_W-1:0] MAX_CHUNK = LINE_NUM_W'(max_chunk(LINE_NUM_W));

  function automatic logic [LINE_NUM_W-1:0] clamp_chunk(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_CHUNK)) return MAX_CHUNK;
    return len[LINE_NUM_W-1:0];
  endfunction

  seq_state_t            state, state_next;
  logic [ADDR_W-1:0]     cur_src, cur_dst, next_src, next_dst;
  logic [LEN_W-1:0]      remaining, next_rem;
  logic [LINE_NUM_W-1:0] chunk;
  move_cmd_t             wr_cmd, head;
  logic                  full, empty, push, pop, set_err;

  assign wr_cmd    = '{src: cmd_src_addr, dst: cmd_dst_addr, len: cmd_len};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign mv_start  = (state == ISSUE);
  assign busy      = (state != IDLE) || !empty;

  rf_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    cmd_done   = 1'b0;
    set_err    = 1'b0;
    next_src   = cur_src + ADDR_W'(chunk);
    next_dst   = cur_dst + ADDR_W'(chunk);
    next_rem   = remaining - LEN_W'(chunk);
    case (state)
      IDLE: begin
        if (!empty && mv_done) begin
          pop = 1'b1;
          if (head.len == '0) set_err    = 1'b1;
          else                state_next = ISSUE;
        end
      end
      ISSUE:    state_next = WAIT_ACK;
      // The engine drops mv_done only after seeing the start, so skip one cycle.
      WAIT_ACK: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (mv_done) begin
          if (next_rem == '0) begin
            cmd_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_src      <= '0;
      cur_dst      <= '0;
      remaining    <= '0;
      chunk        <= '0;
      mv_src_addr  <= '0;
      mv_dst_addr  <= '0;
      mv_line_num  <= '0;
      err_zero_len <= 1'b0;
    end else begin
      if (pop) begin
        cur_src   <= head.src;
        cur_dst   <= head.dst;
        remaining <= head.len;
        chunk     <= clamp_chunk(head.len);
      end else if (state == WAIT_DONE && mv_done) begin
        cur_src   <= next_src;
        cur_dst   <= next_dst;
        remaining <= next_rem;
        chunk     <= clamp_chunk(next_rem);
      end
      // Engine-facing outputs change only when a new chunk is about to issue.
      if (state_next == ISSUE) begin
        mv_src_addr <= pop ? head.src : next_src;
        mv_dst_addr <= pop ? head.dst : next_dst;
        mv_line_num <= pop ? clamp_chunk(head.len) : clamp_chunk(next_rem);
      end
      if (set_err)      err_zero_len <= 1'b1;
      else if (err_clr) err_zero_len <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_move_sequencer.sv
// Directed bench for rf_move_sequencer with a behavioural move engine and a chunk scoreboard.
module tb_rf_move_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_src_addr = '0;
  logic [9:0] cmd_dst_addr = '0;
  logic [11:0] cmd_len = '0;
  logic       mv_start;
  logic [9:0] mv_src_addr;
  logic [9:0] mv_dst_addr;
  logic [7:0] mv_line_num;
  logic       mv_done;
  logic       cmd_done;
  logic       busy;
  logic       err_zero_len;
  logic       err_clr = 1'b0;

  typedef struct {
    logic [9:0] src;
    logic [9:0] dst;
    logic [7:0] n;
    bit         last;
  } chunk_t;

  chunk_t exp_q[$];
  int     checks = 0;
  int     passes = 0;
  int     fails = 0;
  int     exp_done = 0;
  int     done_cnt = 0;
  bit     last_issued_last = 1'b0;
  bit     stall = 1'b0;
  int     eng_cnt = 0;

  always #5 clk = ~clk;

  rf_move_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src_addr (cmd_src_addr),
    .cmd_dst_addr (cmd_dst_addr),
    .cmd_len      (cmd_len),
    .mv_start     (mv_start),
    .mv_src_addr  (mv_src_addr),
    .mv_dst_addr  (mv_dst_addr),
    .mv_line_num  (mv_line_num),
    .mv_done      (mv_done),
    .cmd_done     (cmd_done),
    .busy         (busy),
    .err_zero_len (err_zero_len),
    .err_clr      (err_clr)
  );

  // Move engine: busy for 2 cycles per line after a start; stall freezes it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_done <= 1'b1;
      eng_cnt <= 0;
    end else if (mv_start) begin
      mv_done <= 1'b0;
      eng_cnt <= 2 * int'(mv_line_num);
    end else if (!mv_done && !stall) begin
      if (eng_cnt <= 1) mv_done <= 1'b1;
      eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input logic [9:0] s, input logic [9:0] d, input logic [11:0] l);
    int     rem;
    chunk_t c;
    rem = int'(l);
    if (rem == 0) return;
    exp_done++;
    while (rem > 0) begin
      c.n    = 8'((rem > 255) ? 255 : rem);
      c.src  = s;
      c.dst  = d;
      c.last = (rem == int'(c.n));
      exp_q.push_back(c);
      s   = s + 10'(c.n);
      d   = d + 10'(c.n);
      rem = rem - int'(c.n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_cmd(input logic [9:0] s, input logic [9:0] d, input logic [11:0] l);
    int n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    model_add(s, d, l);
    cmd_valid    = 1'b1;
    cmd_src_addr = s;
    cmd_dst_addr = d;
    cmd_len      = l;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !mv_done) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 5000), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_start"}, 32'(mv_start), 32'd0);
    check({tag, "_src"}, 32'(mv_src_addr), 32'd0);
    check({tag, "_dst"}, 32'(mv_dst_addr), 32'd0);
    check({tag, "_num"}, 32'(mv_line_num), 32'd0);
    check({tag, "_done"}, 32'(cmd_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_zero_len), 32'd0);
  endtask

  // Scoreboard: compare each start against the next expected chunk.
  always @(negedge clk) begin
    if (!rst && mv_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(mv_src_addr), 32'hFFFF_FFFF);
      end else begin
        chunk_t c;
        c = exp_q.pop_front();
        check("chunk_src", 32'(mv_src_addr), 32'(c.src));
        check("chunk_dst", 32'(mv_dst_addr), 32'(c.dst));
        check("chunk_num", 32'(mv_line_num), 32'(c.n));
        last_issued_last = c.last;
      end
    end
    if (!rst && cmd_done) begin
      done_cnt++;
      check("done_on_last_chunk", 32'(last_issued_last), 32'd1);
      check("done_with_mv_done", 32'(mv_done), 32'd1);
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single command and start latency
    push_cmd(10'h010, 10'h200, 12'd4);
    check("lat_pop_cycle_start", 32'(mv_start), 32'd0);
    @(negedge clk);
    check("lat_issue_start", 32'(mv_start), 32'd1);
    wait_idle("single_idle");
    check("single_busy", 32'(busy), 32'd0);
    check("single_done_cnt", 32'(done_cnt), 32'd1);

    // Split with address wrap
    push_cmd(10'h3F0, 10'h100, 12'd300);
    wait_idle("split_idle");
    check("split_done_cnt", 32'(done_cnt), 32'd2);

    // Zero length: error set wins over a coincident clear
    push_cmd(10'h055, 10'h066, 12'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_set_wins", 32'(err_zero_len), 32'd1);
    push_cmd(10'h011, 10'h022, 12'd1);
    wait_idle("zero_idle");
    check("err_sticky", 32'(err_zero_len), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 32'(err_zero_len), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'd3);

    // Backpressure: one in flight plus four queued
    stall = 1'b1;
    push_cmd(10'h100, 10'h180, 12'd2);
    push_cmd(10'h101, 10'h181, 12'd3);
    push_cmd(10'h102, 10'h182, 12'd1);
    push_cmd(10'h103, 10'h183, 12'd5);
    check("ready_before_fourth", 32'(cmd_ready), 32'd1);
    push_cmd(10'h104, 10'h184, 12'd7);
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid    = 1'b1;
    cmd_src_addr = 10'h3AA;
    cmd_dst_addr = 10'h3BB;
    cmd_len      = 12'd9;
    repeat (4) @(negedge clk);
    check("sixth_rejected", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    stall = 1'b0;
    wait_idle("bp_idle");
    check("bp_done_cnt", 32'(done_cnt), 32'd8);

    // Push coinciding with the IDLE pop
    stall = 1'b1;
    push_cmd(10'h200, 10'h280, 12'd3);
    push_cmd(10'h201, 10'h281, 12'd2);
    check("pp_count_before", 32'(dut.u_fifo.count), 32'd1);
    stall = 1'b0;
    n = 0;
    while (!cmd_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pp_first_done", 32'(cmd_done), 32'd1);
    @(negedge clk);
    model_add(10'h202, 10'h282, 12'd4);
    cmd_valid    = 1'b1;
    cmd_src_addr = 10'h202;
    cmd_dst_addr = 10'h282;
    cmd_len      = 12'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pp_count_after", 32'(dut.u_fifo.count), 32'd1);
    wait_idle("pp_idle");
    check("pp_done_cnt", 32'(done_cnt), 32'd11);

    // Reset while the first chunk of a long command is in flight
    push_cmd(10'h020, 10'h040, 12'd300);
    n = 0;
    while (!mv_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_saw_start", 32'(mv_start), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_done--;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_no_done", 32'(done_cnt), 32'd11);
    rst = 1'b0;
    @(negedge clk);
    push_cmd(10'h3FE, 10'h001, 12'd6);
    wait_idle("post_rst_idle");
    check("post_rst_done_cnt", 32'(done_cnt), 32'd12);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_total", 32'(done_cnt), 32'(exp_done));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
